// File: rtl/fpga_img_pkg.sv
// Shared types and helpers for the image-pipeline output blocks.
package fpga_img_pkg;

    typedef enum logic [1:0] {
        CLEAR   = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    localparam int ERR_DUP     = 0;
    localparam int ERR_RANGE   = 1;
    localparam int ERR_OVERRUN = 2;
    localparam int ERR_N       = 3;

    typedef struct packed {
        logic       eof;
        logic       eol;
        logic       sof;
        logic [7:0] data;
    } pix_t;

    function automatic int addr_w(input int npix);
        return (npix > 1) ? $clog2(npix) : 1;
    endfunction

endpackage

// File: rtl/frame_ram.sv
// Simple dual-port frame store: one write port, one registered read port (read-first).
module frame_ram #(
    parameter int DEPTH = 12,
    parameter int AW    = 4,
    parameter int DW    = 9
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/frame_collector.sv
// Collects out-of-order filter beats into a tagged frame store and drains
// the frame in raster order with SOF/EOL/EOF markers.
module frame_collector #(
    parameter int IMAGE_WIDTH  = 320,
    parameter int IMAGE_HEIGHT = 240,
    parameter int COORD_W      = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    ready,
    input  logic                    in_valid,
    input  logic [7:0]              in_data,
    input  logic signed [COORD_W:0] in_row,
    input  logic signed [COORD_W:0] in_col,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [7:0]              out_data,
    output logic                    out_sof,
    output logic                    out_eol,
    output logic                    out_eof,
    output logic [$clog2(IMAGE_WIDTH*IMAGE_HEIGHT+1)-1:0] captured,
    output logic                    dup_err,
    output logic                    range_err,
    output logic                    overrun_err
);
    import fpga_img_pkg::*;

    localparam int NPIX = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int AW   = addr_w(NPIX);
    localparam int CW   = $clog2(NPIX + 1);
    localparam logic signed [COORD_W:0] W_S = (COORD_W+1)'(IMAGE_WIDTH);
    localparam logic signed [COORD_W:0] H_S = (COORD_W+1)'(IMAGE_HEIGHT);

    state_t          state, state_nxt;
    logic [CW-1:0]   addr;
    logic [AW-1:0]   dcol;
    logic            cur_tag, flush_q;
    logic            p_vld, fwd_vld;
    logic [AW-1:0]   p_addr, fwd_addr, in_addr;
    logic [7:0]      p_data;
    logic [8:0]      rd_q;
    logic            r_vld, r_sof, r_eol, r_eof;
    pix_t            fifo [2];
    logic            rp, wp;
    logic [1:0]      cnt;
    logic [ERR_N-1:0] err;

    logic in_range, accept, tag_hit, col_wr, last_pend, leaving;
    logic issue, pop, eof_hs, walk;
    logic            ram_we;
    logic [AW-1:0]   ram_waddr, ram_raddr;
    logic [8:0]      ram_wdata;

    assign in_range = !in_row[COORD_W] && (in_row < H_S) && !in_col[COORD_W] && (in_col < W_S);
    assign in_addr  = AW'(AW'(in_row[COORD_W-1:0]) * AW'(IMAGE_WIDTH) + AW'(in_col[COORD_W-1:0]));

    // The write of the previous beat is not yet visible through the read-first
    // port, so a back-to-back hit on the same address is caught via fwd_*.
    assign tag_hit   = (rd_q[8] == cur_tag) || (fwd_vld && (fwd_addr == p_addr));
    assign col_wr    = p_vld && !tag_hit;
    assign last_pend = col_wr && (captured == CW'(NPIX-1));
    assign leaving   = (state == COLLECT) && (flush_q || last_pend);
    assign ready     = (state == COLLECT) && !flush_q && !last_pend;
    assign accept    = in_valid && ready;

    assign out_valid = (cnt != 2'd0);
    assign pop       = out_valid && out_ready;
    assign eof_hs    = pop && fifo[rp].eof;
    assign issue     = (state == DRAIN) && (addr < CW'(NPIX)) &&
                       (({1'b0, cnt} + {2'b0, r_vld}) <= ({2'b0, pop} + 3'd1));
    assign walk      = ((state == CLEAR) && (addr < CW'(NPIX))) || issue;

    assign out_data    = out_valid ? fifo[rp].data : 8'h00;
    assign out_sof     = out_valid && fifo[rp].sof;
    assign out_eol     = out_valid && fifo[rp].eol;
    assign out_eof     = out_valid && fifo[rp].eof;
    assign dup_err     = err[ERR_DUP];
    assign range_err   = err[ERR_RANGE];
    assign overrun_err = err[ERR_OVERRUN];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= CLEAR;
        else      state <= state_nxt;
    end

    // Drain scrubs each read slot with the current tag so nothing survives the toggle.
    always_comb begin
        state_nxt = state;
        ram_we    = 1'b0;
        ram_waddr = p_addr;
        ram_wdata = {cur_tag, p_data};
        ram_raddr = in_addr;
        case (state)
            CLEAR: begin
                ram_we    = addr < CW'(NPIX);
                ram_waddr = addr[AW-1:0];
                ram_wdata = '0;
                if (addr == CW'(NPIX)) state_nxt = COLLECT;
            end
            COLLECT: begin
                ram_we = col_wr;
                if (leaving) state_nxt = DRAIN;
            end
            DRAIN: begin
                ram_we    = issue;
                ram_waddr = addr[AW-1:0];
                ram_wdata = {cur_tag, 8'h00};
                ram_raddr = addr[AW-1:0];
                if (eof_hs) state_nxt = COLLECT;
            end
            default: state_nxt = CLEAR;
        endcase
    end

    frame_ram #(.DEPTH(NPIX), .AW(AW), .DW(9)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (ram_raddr),
        .rdata (rd_q)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr     <= '0;
            dcol     <= '0;
            cur_tag  <= 1'b0;
            flush_q  <= 1'b0;
            p_vld    <= 1'b0;
            p_addr   <= '0;
            p_data   <= '0;
            fwd_vld  <= 1'b0;
            fwd_addr <= '0;
            r_vld    <= 1'b0;
            r_sof    <= 1'b0;
            r_eol    <= 1'b0;
            r_eof    <= 1'b0;
            fifo[0]  <= '0;
            fifo[1]  <= '0;
            rp       <= 1'b0;
            wp       <= 1'b0;
            cnt      <= '0;
            captured <= '0;
            err      <= '0;
        end else begin
            if (state != state_nxt) begin
                addr <= '0;
                dcol <= '0;
            end else if (walk) begin
                addr <= addr + 1'b1;
                dcol <= (dcol == AW'(IMAGE_WIDTH-1)) ? '0 : dcol + 1'b1;
            end
            if (state == CLEAR && state_nxt == COLLECT) cur_tag <= 1'b1;
            else if (eof_hs)                            cur_tag <= ~cur_tag;
            flush_q  <= (state == COLLECT) && !leaving && flush;
            p_vld    <= accept && in_range;
            p_addr   <= in_addr;
            p_data   <= in_data;
            fwd_vld  <= col_wr;
            fwd_addr <= p_addr;
            r_vld    <= issue;
            r_sof    <= (addr == '0);
            r_eol    <= (dcol == AW'(IMAGE_WIDTH-1));
            r_eof    <= (addr == CW'(NPIX-1));
            if (r_vld) begin
                fifo[wp] <= '{eof: r_eof, eol: r_eol, sof: r_sof,
                              data: (rd_q[8] == cur_tag) ? rd_q[7:0] : 8'h00};
                wp <= ~wp;
            end
            if (pop) rp <= ~rp;
            cnt <= cnt + {1'b0, r_vld} - {1'b0, pop};
            if (eof_hs)      captured <= '0;
            else if (col_wr) captured <= captured + 1'b1;
            if (p_vld && tag_hit)                    err[ERR_DUP]     <= 1'b1;
            if (accept && !in_range)                 err[ERR_RANGE]   <= 1'b1;
            if (in_valid && !ready && state != CLEAR) err[ERR_OVERRUN] <= 1'b1;
        end
    end

endmodule

// File: tb/tb_frame_collector.sv
// Directed bench for frame_collector at 4x3 with a scoreboard of expected drain beats.
module tb_frame_collector;
    localparam int W = 4, H = 3, CWD = 10, NP = W * H;

    logic clk = 1'b0, rst = 1'b1;
    logic ready, in_valid, flush, out_valid, out_ready;
    logic [7:0] in_data, out_data;
    logic signed [CWD:0] in_row, in_col;
    logic out_sof, out_eol, out_eof, dup_err, range_err, overrun_err;
    logic [3:0] captured;

    frame_collector #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .COORD_W(CWD)) dut (
        .clk(clk), .rst(rst), .ready(ready), .in_valid(in_valid), .in_data(in_data),
        .in_row(in_row), .in_col(in_col), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_sof(out_sof), .out_eol(out_eol),
        .out_eof(out_eof), .captured(captured), .dup_err(dup_err), .range_err(range_err),
        .overrun_err(overrun_err));

    always #5 clk = ~clk;

    int n_cmp = 0, n_fail = 0;
    logic [10:0] exp_q[$];
    logic [7:0] mdata[NP];
    bit mwr[NP];
    int mcap = 0, exp_cap = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_clear();
        for (int i = 1; i <= NP; i++) begin
            tick(1);
            chk("clear_ready", ready, 0);
            chk("clear_oval", out_valid, 0);
        end
        tick(1);
        chk("ready_rise", ready, 1);
    endtask

    task automatic beat(input int r, input int c, input int d);
        int t = 0;
        while (!ready && t < 50) begin tick(1); t++; end
        if (t >= 50) chk("beat_wait", ready, 1);
        in_row = (CWD+1)'(r); in_col = (CWD+1)'(c); in_data = 8'(d); in_valid = 1'b1;
        tick(1);
        in_valid = 1'b0;
        if (r >= 0 && r < H && c >= 0 && c < W && !mwr[r*W+c]) begin
            mwr[r*W+c] = 1'b1; mdata[r*W+c] = 8'(d); mcap++;
        end
    endtask

    task automatic push_frame();
        exp_cap = mcap;
        for (int i = 0; i < NP; i++) begin
            exp_q.push_back({i == NP-1, (i % W) == W-1, i == 0, mwr[i] ? mdata[i] : 8'h00});
            mwr[i] = 1'b0;
        end
        mcap = 0;
    endtask

    task automatic drain(input bit stall, input bit poke);
        int got = 0, it = 0, first = -1, last_hs = -1;
        bit held = 1'b0;
        logic [7:0] held_d = '0;
        logic [10:0] e;
        while (got < NP && it < 200) begin
            out_ready = stall ? ((it % 4) == 0 || (it % 4) == 3) : 1'b1;
            if (poke) begin
                in_valid = (it == 5); in_row = '0; in_col = '0; in_data = 8'h55;
            end
            if (held) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, held_d);
                held = 1'b0;
            end
            if (out_valid) begin
                if (first < 0) begin
                    first = it;
                    chk("first_lat", it, 3);
                    chk("drain_cap", captured, exp_cap);
                end
                chk("drain_ready", ready, 0);
                if (out_ready) begin
                    if (exp_q.size() == 0) chk("sb_empty", 0, 1);
                    else begin
                        e = exp_q.pop_front();
                        chk("pix", {out_eof, out_eol, out_sof, out_data}, e);
                    end
                    if (!stall && last_hs >= 0) chk("gap", it - last_hs, 1);
                    last_hs = it;
                    got++;
                end else begin
                    held = 1'b1; held_d = out_data;
                end
            end
            tick(1);
            it++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("drain_count", got, NP);
        chk("ready_after_eof", ready, 1);
        chk("cap_zero", captured, 0);
    endtask

    initial begin
        in_valid = 0; in_data = '0; in_row = '0; in_col = '0; flush = 0; out_ready = 1;
        #2 rst = 1'b0;
        tick(3);
        chk("rst_ready", ready, 0);
        chk("rst_oval", out_valid, 0);
        chk("rst_odata", out_data, 0);
        chk("rst_marks", {out_sof, out_eol, out_eof}, 0);
        chk("rst_cap", captured, 0);
        chk("rst_errs", {dup_err, range_err, overrun_err}, 0);
        rst = 1'b1;
        wait_clear();

        for (int i = 0; i < NP; i++) beat(i / W, i % W, i * 10);
        push_frame();
        drain(1'b0, 1'b0);
        chk("no_dup", dup_err, 0);

        for (int i = NP-1; i >= 0; i--) begin
            beat(i / W, i % W, 100 + i);
            if (i == 6) beat(1, 2, 255);
        end
        push_frame();
        drain(1'b0, 1'b0);
        chk("dup_set", dup_err, 1);
        chk("range_clear", range_err, 0);

        beat(-1, 0, 1); beat(0, 4, 2); beat(3, 0, 3);
        tick(2);
        chk("range_set", range_err, 1);
        chk("range_cap", captured, 0);
        for (int i = 0; i < NP; i++) beat(i / W, i % W, 200 + i);
        push_frame();
        drain(1'b0, 1'b0);

        beat(0, 0, 1);
        chk("cap_lag", captured, 0);
        tick(1);
        chk("cap_upd", captured, 1);
        beat(0, 3, 2); beat(1, 1, 3); beat(2, 0, 4); beat(2, 3, 5);
        tick(2);
        chk("cap_five", captured, 5);
        chk("no_overrun", overrun_err, 0);
        flush = 1'b1; tick(1); flush = 1'b0;
        push_frame();
        drain(1'b0, 1'b1);
        chk("overrun_set", overrun_err, 1);

        flush = 1'b1;
        beat(1, 0, 77);
        flush = 1'b0;
        push_frame();
        drain(1'b1, 1'b0);

        flush = 1'b1; tick(1); flush = 1'b0;
        tick(6);
        chk("mid_valid", out_valid, 1);
        rst = 1'b0;
        #1;
        chk("rst_mid_oval", out_valid, 0);
        chk("rst_mid_ready", ready, 0);
        chk("rst_mid_odata", out_data, 0);
        chk("rst_mid_errs", {dup_err, range_err, overrun_err}, 0);
        #2 rst = 1'b1;
        wait_clear();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/frame_collector.md
# frame_collector

Output-side counterpart to the window filters (gauss5x5 and siblings). It accepts filter results as (valid, data, row, col) beats, which may arrive out of raster order or duplicated, and writes them into an on-chip frame store. Once a full frame is held, or on a flush request, it streams the frame out in raster order on a valid/ready interface with SOF/EOL/EOF markers. It sits between a filter core and the writeback/DMA or video output path.

## Interface
- IMAGE_WIDTH, 320, pixels per row
- IMAGE_HEIGHT, 240, rows per frame
- COORD_W, 10, coordinate magnitude bits; in_row/in_col are signed COORD_W+1
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- ready  out  1  high when beats are accepted (COLLECT state)
- in_valid  in  1  result beat present
- in_data  in  8  filtered pixel
- in_row, in_col  in  COORD_W+1  signed centre coordinate of the beat
- flush  in  1  force drain of a partial frame
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accept
- out_data  out  8  raster-order pixel, 0 for pixels never written
- out_sof, out_eol, out_eof  out  1  first pixel / last of row / last of frame, qualified by out_valid
- captured  out  $clog2(W*H+1)  unique pixels stored this frame
- dup_err, range_err, overrun_err  out  1  sticky error flags, cleared only by rst

## Operation
- States: CLEAR, COLLECT, DRAIN.
- CLEAR (entered on reset): walks all W*H addresses and writes tag=0, data=0. Takes W*H cycles. ready=0. Then sets cur_tag=1 and goes to COLLECT.
- COLLECT, beat with in_valid=1:
  - If the coordinate is in range (0≤row<H, 0≤col<W) and the stored tag ≠ cur_tag: write data and cur_tag at row*W+col, captured+1.
  - If the tag already equals cur_tag: drop the beat (first write wins) and set dup_err.
  - If the coordinate is out of range: drop the beat and set range_err.
- Tag lookup is a synchronous read, so a write commits one cycle after acceptance. A back-to-back beat to the same address must see the pending write (forwarding) and is treated as a duplicate.
- COLLECT→DRAIN when captured reaches W*H, or when flush=1 is sampled. A beat presented in the same cycle as flush is accepted first.
- DRAIN: reads addresses 0..W*H-1 in order.
  - out_data = stored data if tag==cur_tag, else 0.
  - Markers: out_sof at address 0, out_eol at col W-1, out_eof at W*H-1.
  - A 2-entry skid holds read data under backpressure. out_valid/out_data are held stable while out_ready=0.
  - in_valid during DRAIN: beat ignored, overrun_err set.
- After the EOF handshake: cur_tag toggles, captured←0, go to COLLECT. No re-clear is needed because the tag toggle invalidates the previous frame.
- Reset asserted mid-operation: immediate return to CLEAR. All outputs take their reset values and any frame in progress is lost.

## Timing
- Reset values: ready=0, out_valid=0, out_data=0, all markers 0, captured=0, all error flags 0, state=CLEAR.
- ready rises W*H+1 cycles after rst deasserts.
- captured updates the cycle after the beat.
- The DRAIN transition occurs the cycle after the completing beat or flush; ready falls in that same cycle.
- First out_valid is 2 cycles after DRAIN entry (RAM read latency plus register).
- With out_ready held high: one pixel per cycle, and the full frame drains in W*H cycles after the first beat.
- ready rises the cycle after the EOF handshake.

## Structure
- Shared package fpga_img_pkg:
  - state enum {CLEAR, COLLECT, DRAIN}
  - address-width function (clog2 of W*H)
  - error flag index constants
- Sub-module frame_ram: simple dual-port, W*H × 9 bits ({tag, data[7:0]}), one write port, one synchronous read port, no reset on the array. The tag read for duplicate check and the drain read share the read port, which is legal because COLLECT and DRAIN are mutually exclusive.

## Test plan
- W=4, H=3. Reset, then hold in_valid=0 → ready=0 for 12 cycles, rises at cycle 13; all outputs read 0 during CLEAR.
- Raster beats with data=idx*10 (0..110), out_ready=1 → DRAIN entered after beat 11; outputs 0,10..110 on consecutive cycles:
  - out_sof on the first beat
  - out_eol on pixels 3, 7, 11
  - out_eof on 11
  - ready returns afterwards
- Reverse-order beats, plus a second write to (1,2) with data 0xFF → original value kept, dup_err=1, captured=12.
- Beats at row=-1, col=4, and row=3 → dropped, range_err=1, captured stays 0; then a valid frame drains normally.
- 5 beats then flush → 12 outputs, with unwritten pixels equal to 0. A beat asserted during DRAIN sets overrun_err. A second frame drains without stale data (tag toggle).
- out_ready toggled 1-0-0-1 during drain → no pixel lost or repeated, data stable while stalled. rst pulsed mid-drain → out_valid=0 immediately and CLEAR restarts.
